// File: rtl/addr_region_decoder.sv
// addr_region_decoder: registered multi-window address decoder with per-region wait states and sticky fault logging
module addr_region_decoder #(
  parameter int N_REGIONS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_LO = {32'h0000_0000, 32'h0000_8F11},
  parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_HI = {32'h0000_0FFF, 32'h0000_9310},
  parameter logic [N_REGIONS*4-1:0] REGION_WAIT = {4'd2, 4'd0},
  localparam int RW = N_REGIONS > 1 ? $clog2(N_REGIONS) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic WE,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic fault_clr,
  output logic [N_REGIONS-1:0] CS,
  output logic iWE,
  output logic [ADDR_WIDTH-1:0] iAddress,
  output logic [RW-1:0] region,
  output logic ready,
  output logic busy,
  output logic fault,
  output logic fault_sticky,
  output logic [ADDR_WIDTH-1:0] fault_addr
);
  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic hit;
  logic miss;
  logic [RW-1:0] idx;
  logic [ADDR_WIDTH-1:0] off;
  logic [3:0] wt;
  // scan from the top so the lowest-index hit overwrites the others; LO > HI can never hit
  always_comb begin
    hit = 1'b0;
    idx = '0;
    off = '0;
    wt = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--)
      if (address >= REGION_LO[i*ADDR_WIDTH +: ADDR_WIDTH] && address <= REGION_HI[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = RW'(i);
        off = address - REGION_LO[i*ADDR_WIDTH +: ADDR_WIDTH];
        wt = REGION_WAIT[i*4 +: 4];
      end
  end
  assign miss = state == IDLE && req && !hit;
  assign busy = state != IDLE;
  // access state machine with registered outputs; a new fault beats fault_clr on the same edge
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      CS <= '0;
      iWE <= 1'b0;
      iAddress <= '0;
      region <= '0;
      ready <= 1'b0;
      fault <= 1'b0;
      fault_sticky <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault_sticky <= miss | (fault_sticky & ~fault_clr);
      case (state)
        IDLE:
          if (req && hit) begin
            state <= ACCESS;
            cnt <= wt;
            CS <= N_REGIONS'(1) << idx;
            iWE <= WE;
            iAddress <= off;
            region <= idx;
            ready <= wt == 4'd0;
          end else if (req) begin
            state <= FAULT;
            fault_addr <= address;
            ready <= 1'b1;
            fault <= 1'b1;
          end
        ACCESS:
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            ready <= cnt == 4'd1;
          end else begin
            state <= IDLE;
            CS <= '0;
            iWE <= 1'b0;
            iAddress <= '0;
            region <= '0;
            ready <= 1'b0;
          end
        FAULT: begin
          state <= IDLE;
          ready <= 1'b0;
          fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_addr_region_decoder.sv
// tb_addr_region_decoder: randomized scoreboard bench for addr_region_decoder
module tb_addr_region_decoder;
  logic clk = 0;
  logic reset = 1;
  logic req = 0;
  logic WE = 0;
  logic [31:0] address = 0;
  logic fault_clr = 0;
  logic [1:0] CS;
  logic iWE;
  logic [31:0] iAddress;
  logic [0:0] region;
  logic ready, busy, fault, fault_sticky;
  logic [31:0] fault_addr;

  logic o_req = 0;
  logic o_we = 0;
  logic [31:0] o_addr = 0;
  logic o_clr = 0;
  logic [1:0] o_cs;
  logic o_iwe;
  logic [31:0] o_iaddr;
  logic [0:0] o_region;
  logic o_ready, o_busy, o_fault, o_sticky;
  logic [31:0] o_faddr;

  always #5 clk = ~clk;

  addr_region_decoder dut (
    .clock(clk), .reset(reset), .req(req), .WE(WE), .address(address), .fault_clr(fault_clr),
    .CS(CS), .iWE(iWE), .iAddress(iAddress), .region(region), .ready(ready), .busy(busy),
    .fault(fault), .fault_sticky(fault_sticky), .fault_addr(fault_addr)
  );

  addr_region_decoder #(
    .REGION_LO({32'h0000_8F00, 32'h0000_8F11}),
    .REGION_HI({32'h0000_8FFF, 32'h0000_9310})
  ) u_ov (
    .clock(clk), .reset(reset), .req(o_req), .WE(o_we), .address(o_addr), .fault_clr(o_clr),
    .CS(o_cs), .iWE(o_iwe), .iAddress(o_iaddr), .region(o_region), .ready(o_ready), .busy(o_busy),
    .fault(o_fault), .fault_sticky(o_sticky), .fault_addr(o_faddr)
  );

  typedef struct {
    logic [1:0] cs;
    logic we;
    logic [31:0] off;
    logic rg;
    logic flt;
    int w;
    logic sticky;
    logic [31:0] faddr;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int tests = 0;
  int fails = 0;
  logic m_sticky = 0;
  logic [31:0] m_faddr = 0;
  logic [31:0] lo_m [2] = '{32'h8F11, 32'h0000};
  logic [31:0] hi_m [2] = '{32'h9310, 32'h0FFF};
  int w_m [2] = '{0, 2};
  logic [31:0] edges [8] = '{32'h0, 32'hFFF, 32'h1000, 32'h8F10, 32'h8F11, 32'h9310, 32'h9311, 32'hFFFF_FFFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // reference: first window (lowest index) containing the address, else a fault
  task automatic do_req(input logic [31:0] a, input logic we, input logic clr, input int noise);
    exp_t e;
    int h = -1;
    for (int i = 0; i < 2; i++)
      if (h < 0 && a >= lo_m[i] && a <= hi_m[i]) h = i;
    if (h < 0) begin
      m_sticky = 1;
      m_faddr = a;
      e.cs = 2'b00; e.we = 0; e.off = 0; e.rg = 0; e.flt = 1; e.w = 0;
    end else begin
      if (clr) m_sticky = 0;
      e.cs = h == 0 ? 2'b01 : 2'b10; e.we = we; e.off = a - lo_m[h]; e.rg = h == 1; e.flt = 0; e.w = w_m[h];
    end
    e.sticky = m_sticky;
    e.faddr = m_faddr;
    q.push_back(e);
    req = 1; WE = we; address = a; fault_clr = clr;
    step;
    req = 0; fault_clr = 0;
    for (int j = 0; j <= e.w; j++) begin
      if (noise == 1) begin
        req = 1; address = 32'h8F20;
      end else if (noise == 2) begin
        req = 1'($urandom_range(0, 1)); address = $urandom; WE = 1'($urandom_range(0, 1));
      end
      step;
    end
    req = 0;
  endtask

  int bcnt = 0;
  logic prev_ready = 0;
  // monitor: pops the scoreboard whenever the DUT presents ready
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
      prev_ready = 0;
    end else begin
      if (prev_ready) chk("idle_after_ready", busy, 0);
      prev_ready = ready;
      bcnt = busy ? bcnt + 1 : 0;
      if (!ready) chk("fault_without_ready", fault, 0);
      if (busy && q.size() > 0) begin
        chk("cs_hold", CS, q[0].cs);
        chk("iaddr_hold", iAddress, q[0].off);
      end
      if (ready) begin
        if (q.size() == 0) chk("spurious_ready", ready, 0);
        else begin
          m_e = q.pop_front();
          chk("cs", CS, m_e.cs);
          chk("iwe", iWE, m_e.we);
          chk("iaddress", iAddress, m_e.off);
          chk("region", region, m_e.rg);
          chk("fault", fault, m_e.flt);
          chk("fault_sticky", fault_sticky, m_e.sticky);
          chk("fault_addr", fault_addr, m_e.faddr);
          chk("latency", bcnt, m_e.w + 1);
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    int pick;
    logic [31:0] a;
    repeat (3) step;
    reset = 0;
    chk("rst_cs", CS, 0);
    chk("rst_iwe", iWE, 0);
    chk("rst_iaddr", iAddress, 0);
    chk("rst_region", region, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_sticky", fault_sticky, 0);
    chk("rst_faddr", fault_addr, 0);
    step;
    do_req(32'h8F11, 1, 0, 0);
    do_req(32'h0010, 0, 0, 0);
    do_req(32'h9310, 1, 0, 0);
    do_req(32'h9311, 0, 0, 0);
    do_req(32'h8F10, 1, 0, 0);
    do_req(32'h0FFF, 1, 0, 1);
    chk("sticky_after_hit", fault_sticky, 1);
    fault_clr = 1;
    step;
    fault_clr = 0;
    m_sticky = 0;
    chk("sticky_clr", fault_sticky, 0);
    do_req(32'h1000, 0, 1, 0);
    chk("sticky_set_wins", fault_sticky, 1);
    do_req(32'h0123, 1, 0, 1);
    req = 1; WE = 1; address = 32'h0010;
    step;
    req = 0;
    step;
    reset = 1;
    step;
    chk("abort_cs", CS, 0);
    chk("abort_iaddr", iAddress, 0);
    chk("abort_ready", ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sticky", fault_sticky, 0);
    chk("abort_faddr", fault_addr, 0);
    reset = 0;
    m_sticky = 0;
    m_faddr = 0;
    step;
    chk("abort_no_ready", ready, 0);
    for (int n = 0; n < 250; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: a = 32'($urandom_range(0, 32'hFFF));
        1: a = 32'h8F11 + 32'($urandom_range(0, 32'h3FF));
        2: a = edges[$urandom_range(0, 7)];
        3: a = $urandom;
        default: a = 32'h8E00 + 32'($urandom_range(0, 32'h600));
      endcase
      do_req(a, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 2);
    end
    o_req = 1; o_we = 1; o_addr = 32'h8F20;
    step;
    o_req = 0;
    chk("ov_cs", o_cs, 2'b01);
    chk("ov_region", o_region, 0);
    chk("ov_iaddr", o_iaddr, 32'h0F);
    chk("ov_ready", o_ready, 1);
    repeat (5) step;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
